// File: rtl/sr_pulse_driver_if.sv
// Request/status handshake between clocked control logic and sr_pulse_driver.
interface sr_pulse_driver_if;
    logic req_valid;
    logic req_set;
    logic req_ready;
    logic done;
    logic err;
    logic busy;

    modport master (
        output req_valid,
        output req_set,
        input  req_ready,
        input  done,
        input  err,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_set,
        output req_ready,
        output done,
        output err,
        output busy
    );
endinterface

// File: rtl/sr_pulse_driver.sv
// Drives preset/clear pulses into an async NAND SR latch, then confirms the
// latch state through a 2-flop synchronizer and reports done or timeout.
module sr_pulse_driver #(
    parameter int unsigned PW  = 4,
    parameter int unsigned GAP = 2,
    parameter int unsigned TMO = 16,
    parameter int unsigned CW  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_pulse_driver_if.slave   bus,
    output logic               preset_n,
    output logic               clear_n,
    input  logic               q_in,
    input  logic               qbar_in,
    output logic               q_sync,
    output logic               bad
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PULSE   = 2'd1;
    localparam logic [1:0] S_CONFIRM = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    localparam int unsigned PW_E  = (PW  == 0) ? 1 : PW;
    localparam int unsigned GAP_E = (GAP == 0) ? 1 : GAP;

    localparam logic [CW-1:0] PW_L  = CW'(PW_E);
    localparam logic [CW-1:0] GAP_L = CW'(GAP_E);
    localparam logic [CW-1:0] TMO_L = CW'(TMO);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          set_r, set_n;
    logic          q1, qb1, qbs;
    logic          done_n, err_n;
    logic          preset_n_n, clear_n_n;
    logic          match;

    assign match = (q_sync == set_r) && (qbs == !set_r);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            set_r <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            set_r <= set_n;
        end
    end

    // Next state; every phase counts down to 1 so the last cycle is the one with cnt == 1.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        set_n   = set_r;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    set_n   = bus.req_set;
                    cnt_n   = PW_L;
                    state_n = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt <= ONE) begin
                    cnt_n   = TMO_L;
                    state_n = S_CONFIRM;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            S_CONFIRM: begin
                if (match) begin
                    done_n  = 1'b1;
                    cnt_n   = GAP_L;
                    state_n = S_GAP;
                end else if (cnt <= ONE) begin
                    err_n   = 1'b1;
                    cnt_n   = GAP_L;
                    state_n = S_GAP;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            S_GAP: begin
                if (cnt <= ONE) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // Strobes decode the next state so they are flop outputs aligned with PULSE entry.
        preset_n_n = !((state_n == S_PULSE) && set_n);
        clear_n_n  = !((state_n == S_PULSE) && !set_n);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset_n      <= 1'b1;
            clear_n       <= 1'b1;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
        end else begin
            preset_n      <= preset_n_n;
            clear_n       <= clear_n_n;
            bus.done      <= done_n;
            bus.err       <= err_n;
            bus.busy      <= (state_n != S_IDLE);
            bus.req_ready <= (state_n == S_IDLE);
        end
    end

    // Latch synchronizer; bad is computed from stage 1 so it lines up with q_sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1     <= 1'b0;
            q_sync <= 1'b0;
            qb1    <= 1'b0;
            qbs    <= 1'b0;
            bad    <= 1'b1;
        end else begin
            q1     <= q_in;
            q_sync <= q1;
            qb1    <= qbar_in;
            qbs    <= qb1;
            bad    <= (q1 == qb1);
        end
    end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver with a behavioural NAND latch model on each instance.
module tb_sr_pulse_driver;

    typedef struct packed {
        logic v;
        logic s;
        logic pn;
        logic cn;
        logic dn;
        logic rdy;
        logic bsy;
        logic qs;
    } vec_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    logic preset_n0, clear_n0, q_sync0, bad0, q_in0, qbar_in0;
    logic preset_n1, clear_n1, q_sync1, bad1, q_in1, qbar_in1;
    logic disc0;
    logic lq0 = 1'b0;
    logic lq1 = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    vec_t tab [16];

    sr_pulse_driver_if bus0 ();
    sr_pulse_driver_if bus1 ();

    sr_pulse_driver #(.PW(4), .GAP(2), .TMO(16), .CW(5)) u0 (
        .clk(clk), .rst_n(rst0), .bus(bus0),
        .preset_n(preset_n0), .clear_n(clear_n0),
        .q_in(q_in0), .qbar_in(qbar_in0),
        .q_sync(q_sync0), .bad(bad0)
    );

    sr_pulse_driver #(.PW(0), .GAP(0), .TMO(16), .CW(5)) u1 (
        .clk(clk), .rst_n(rst1), .bus(bus1),
        .preset_n(preset_n1), .clear_n(clear_n1),
        .q_in(q_in1), .qbar_in(qbar_in1),
        .q_sync(q_sync1), .bad(bad1)
    );

    always #5 clk = ~clk;

    // Cross-coupled NAND latch: a low strobe forces q, otherwise it holds.
    always @(negedge preset_n0 or negedge clear_n0) begin
        if (!preset_n0)     lq0 <= 1'b1;
        else if (!clear_n0) lq0 <= 1'b0;
    end
    always @(negedge preset_n1 or negedge clear_n1) begin
        if (!preset_n1)     lq1 <= 1'b1;
        else if (!clear_n1) lq1 <= 1'b0;
    end

    assign q_in0    = disc0 ? 1'b1 : lq0;
    assign qbar_in0 = disc0 ? 1'b1 : !lq0;
    assign q_in1    = lq1;
    assign qbar_in1 = !lq1;

    always @(negedge clk) begin
        assert (preset_n0 || clear_n0) else begin
            miscompares++;
            $error("FAIL strobe_overlap u0: preset_n=%b clear_n=%b, required never both 0", preset_n0, clear_n0);
        end
        assert (preset_n1 || clear_n1) else begin
            miscompares++;
            $error("FAIL strobe_overlap u1: preset_n=%b clear_n=%b, required never both 0", preset_n1, clear_n1);
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    initial begin
        // Set then clear, req_valid held from edge 0 through the second accept.
        tab = '{8'b1101_0010, 8'b1001_0010, 8'b1001_0011, 8'b1001_0011,
                8'b1011_0011, 8'b1011_1011, 8'b1011_0011, 8'b1011_0101,
                8'b1010_0011, 8'b0010_0011, 8'b0010_0010, 8'b0010_0010,
                8'b0011_0010, 8'b0011_1010, 8'b0011_0010, 8'b0011_0100};

        rst0 = 1'b0; rst1 = 1'b0; disc0 = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_set = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_set = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",   bus0.req_ready, 1'b1);
        chk("rst_busy",    bus0.busy,      1'b0);
        chk("rst_done",    bus0.done,      1'b0);
        chk("rst_err",     bus0.err,       1'b0);
        chk("rst_preset",  preset_n0,      1'b1);
        chk("rst_clear",   clear_n0,       1'b1);
        chk("rst_qsync",   q_sync0,        1'b0);
        chk("rst_bad",     bad0,           1'b1);
        chk("rst_ready_1", bus1.req_ready, 1'b1);
        rst0 = 1'b1; rst1 = 1'b1;

        repeat (4) @(posedge clk);
        #1;
        chk("fill_qsync0", q_sync0, 1'b0);
        chk("fill_bad0",   bad0,    1'b0);
        chk("fill_qsync1", q_sync1, 1'b1);
        chk("fill_bad1",   bad1,    1'b0);

        // Table sequence: edge 0 is the next edge, row k describes edge k+1.
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            bus0.req_valid = tab[k].v;
            bus0.req_set   = tab[k].s;
            @(posedge clk);
            #1;
            chk($sformatf("A%0d_preset_n", k + 1), preset_n0,      tab[k].pn);
            chk($sformatf("A%0d_clear_n",  k + 1), clear_n0,       tab[k].cn);
            chk($sformatf("A%0d_done",     k + 1), bus0.done,      tab[k].dn);
            chk($sformatf("A%0d_err",      k + 1), bus0.err,       1'b0);
            chk($sformatf("A%0d_ready",    k + 1), bus0.req_ready, tab[k].rdy);
            chk($sformatf("A%0d_busy",     k + 1), bus0.busy,      tab[k].bsy);
            chk($sformatf("A%0d_q_sync",   k + 1), q_sync0,        tab[k].qs);
            chk($sformatf("A%0d_bad",      k + 1), bad0,           1'b0);
        end
        bus0.req_valid = 1'b0;

        // Latch disconnected: set request must time out.
        disc0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("B_bad_pre", bad0, 1'b1);
        bus0.req_valid = 1'b1;
        bus0.req_set   = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            @(posedge clk);
            #1;
            bus0.req_valid = 1'b0;
            chk($sformatf("B%0d_preset_n", k), preset_n0,      !(k <= 4));
            chk($sformatf("B%0d_done",     k), bus0.done,      1'b0);
            chk($sformatf("B%0d_err",      k), bus0.err,       (k == 21));
            chk($sformatf("B%0d_bad",      k), bad0,           1'b1);
            chk($sformatf("B%0d_ready",    k), bus0.req_ready, (k >= 23));
        end
        disc0 = 1'b0;

        // Reset asserted mid-pulse.
        repeat (3) @(posedge clk);
        #1;
        bus0.req_valid = 1'b1;
        bus0.req_set   = 1'b1;
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        chk("C1_preset_n", preset_n0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        #1;
        chk("C_rst_preset_n", preset_n0,      1'b1);
        chk("C_rst_clear_n",  clear_n0,       1'b1);
        chk("C_rst_busy",     bus0.busy,      1'b0);
        chk("C_rst_ready",    bus0.req_ready, 1'b1);
        chk("C_rst_done",     bus0.done,      1'b0);
        chk("C_rst_err",      bus0.err,       1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("C_hold_preset_n", preset_n0, 1'b1);
            chk("C_hold_busy",     bus0.busy, 1'b0);
        end
        rst0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("C_post%0d_done",     k), bus0.done,      1'b0);
            chk($sformatf("C_post%0d_err",      k), bus0.err,       1'b0);
            chk($sformatf("C_post%0d_busy",     k), bus0.busy,      1'b0);
            chk($sformatf("C_post%0d_ready",    k), bus0.req_ready, 1'b1);
            chk($sformatf("C_post%0d_preset_n", k), preset_n0,      1'b1);
        end

        // PW=0/GAP=0 instance: set onto an already-set latch, then clear.
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b1;
        bus1.req_set   = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            bus1.req_valid = 1'b0;
            chk($sformatf("D%0d_preset_n", k), preset_n1,      !(k == 1));
            chk($sformatf("D%0d_clear_n",  k), clear_n1,       1'b1);
            chk($sformatf("D%0d_done",     k), bus1.done,      (k == 3));
            chk($sformatf("D%0d_err",      k), bus1.err,       1'b0);
            chk($sformatf("D%0d_ready",    k), bus1.req_ready, (k == 4));
        end
        bus1.req_valid = 1'b1;
        bus1.req_set   = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            bus1.req_valid = 1'b0;
            chk($sformatf("E%0d_clear_n",  k), clear_n1,       !(k == 1));
            chk($sformatf("E%0d_preset_n", k), preset_n1,      1'b1);
            chk($sformatf("E%0d_done",     k), bus1.done,      (k == 4));
            chk($sformatf("E%0d_ready",    k), bus1.req_ready, (k == 5));
        end
        chk("E_q_sync", q_sync1, 1'b0);
        chk("E_bad",    bad1,    1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sr_pulse_driver.md
# sr_pulse_driver

Synchronous driver for an asynchronous cross-coupled NAND preset/clear latch. Accepts set/clear requests over a valid/ready handshake and emits active-low preset or clear pulses of programmed width. It then confirms the latch output through a 2-flop synchronizer and reports done or timeout error. It sits between clocked control logic and the latch, and enforces a recovery gap so preset and clear are never low together.

## Interface
- PW, 4: pulse width in clock cycles (0 treated as 1)
- GAP, 2: recovery cycles with both strobes high after each operation (0 treated as 1)
- TMO, 16: confirm window in cycles before error
- CW, 5: width of internal cycle counter; must hold max(PW, GAP, TMO)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_set  input  1  1 = preset (drive q=1), 0 = clear (drive q=0); sampled on accept
- req_ready  output  1  high only in IDLE
- preset_n  output  1  active-low preset strobe to latch
- clear_n  output  1  active-low clear strobe to latch
- q_in  input  1  latch q, asynchronous
- qbar_in  input  1  latch qbar, asynchronous
- done  output  1  one-cycle pulse, confirm succeeded
- err  output  1  one-cycle pulse, confirm timed out
- busy  output  1  high in any state but IDLE
- q_sync  output  1  synchronized q (2nd sync flop)
- bad  output  1  synchronized q == synchronized qbar (illegal/forbidden latch state)

## Operation
- Reset (rst_n low, asynchronous): state IDLE; preset_n=1, clear_n=1, done=0, err=0, busy=0, counter=0, all sync flops 0, so q_sync=0 and bad=1 until the synchronizer fills. req_ready=1 once state is IDLE (during and after reset).
- Synchronizer: q_in and qbar_in each pass through 2 flops. match = (qs == req_set_r) && (qbs == !req_set_r).
- IDLE: on req_valid && req_ready, capture req_set into req_set_r. Next state is PULSE and the counter loads PW.
- PULSE: drive preset_n=0 if req_set_r, else clear_n=0. The other strobe stays 1. After PW cycles, release the strobe and go to CONFIRM with counter = TMO.
- CONFIRM: both strobes 1. Each cycle:
  - if match: done=1 for the next cycle, go to GAP.
  - else if counter expires: err=1 for the next cycle, go to GAP.
  - else decrement the counter.
  - bad=1 counts as no match.
- GAP: both strobes 1 for GAP cycles, then IDLE.
- Invariant: preset_n and clear_n are never 0 together. All strobe outputs are driven from flops, with no glitches.
- A request whose target already matches the latch is still pulsed and confirmed normally.
- req_valid outside IDLE is ignored; the requester must hold it until ready.
- done and err are mutually exclusive per operation.

## Timing
- Edge 0 accepts the request. Strobe is low from edge 1 to edge 1+PW.
- Edge 1+PW enters CONFIRM. With the latch settled during the pulse (PW ≥ 2), match is seen in the first CONFIRM cycle and done is high from edge 2+PW for one cycle.
- Earliest next accept is edge 2+PW+GAP; req_ready rises at that edge.
- Timeout: err is high from edge 1+PW+TMO for one cycle, and IDLE follows at edge 1+PW+TMO+GAP.
- Reset mid-PULSE forces the strobes high asynchronously with no further output. The operation is dropped, with no done and no err.
- q_sync and bad lag the latch by 2 cycles.

## Test plan
- Reset then set, PW=4, GAP=2, with the latch model attached:
  - preset_n low on edges 1–5, clear_n stays 1.
  - done=1 at edge 6 only, req_ready=1 at edge 8.
  - q_sync=1, bad=0.
- Clear following a set, back-to-back with req_valid held:
  - second accept at edge 8.
  - clear_n low edges 9–13, done at edge 14, q_sync=0.
- Latch disconnected (q_in=qbar_in=1), set request:
  - no done; err=1 at edge 21 (TMO=16).
  - bad=1 throughout; req_ready at edge 23.
- req_valid held high throughout: exactly one accept per operation, and preset_n/clear_n never both 0 (assertion).
- rst_n pulled low at edge 3 mid-pulse: preset_n=1 immediately, busy=0, done/err stay 0, and IDLE on release.
- PW=0, GAP=0: each behaves as 1; strobe low for exactly one cycle, done at edge 3.
